rv_mem_arbiter: RTL and testbench
=================================

Name: rv_mem_arbiter

Overview:
- Shares one single-port, synchronous-read memory between the multicycle core's instruction-fetch port and data port, replacing the separate imem/dmem arrays with a unified memory.
- Provides a req/ack handshake per requester and two-requester round-robin arbitration.
- Detects the completion write sequence (0xDEAD to address 0xFFFF), suppresses that write to memory and raises a sticky done flag for the simulation top.

Parameters:
DPWIDTH, 32, address/data width of both requester ports
LOGMEM_SIZE, 10, log2 of memory depth in 32-bit words
DONE_ADDR, 32'h0000FFFF, byte address of the completion write
DONE_DATA, 32'h0000DEAD, data value of the completion write

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  reset; synchronous, active-low (rst=0 resets on the next posedge)
if_req  in  1  fetch request; held with if_addr stable until if_ack
if_addr  in  DPWIDTH  fetch byte address
if_rdata  out  DPWIDTH  fetch read data; valid while if_ack=1
if_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held with d_we, d_addr and d_wdata stable until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  DPWIDTH  data byte address
d_wdata  in  DPWIDTH  data write value
d_rdata  out  DPWIDTH  data read value; valid while d_ack=1
d_ack  out  1  one-cycle data completion pulse
mem_addr  out  LOGMEM_SIZE  word address to memory
mem_we  out  1  memory write enable
mem_wdata  out  DPWIDTH  memory write data
mem_rdata  in  DPWIDTH  memory read data; valid the cycle after the address is presented
done  out  1  sticky completion flag

Behaviour:
- FSM states are IDLE, ACC and ACK. Reset state is IDLE.
  - IDLE -> ACC when any req=1 is sampled. The winner and its request fields are latched.
  - ACC -> ACK unconditionally. mem_addr, mem_we and mem_wdata are driven from the latched request during ACC only.
  - ACK -> IDLE unconditionally. The granted port's ack=1 and its rdata=mem_rdata.
- Latency: req sampled at edge N; ack is high during the cycle after edge N+1. Throughput is one access per 3 cycles.
- Requester rule: req must be low in the cycle after ack. Because IDLE always follows ACK, a completed request is never re-granted.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the port not granted last wins (round-robin).
  - The last_grant register resets to DATA, so fetch wins the first tie.
- Addressing: mem_addr = addr[LOGMEM_SIZE+1:2]. Bits [1:0] and upper bits are ignored, so addresses wrap modulo the memory size and there is no error response.
- Outputs outside their active cycles:
  - mem_we=0 and mem_addr/mem_wdata=0 except during ACC.
  - ack=0 except during ACK.
  - rdata holds the last value delivered on that port. It is 0 after reset.
- Writes: d_rdata during the write's ACK cycle equals the previous held value.
- Completion:
  - Detected when a granted data write has latched d_addr==DONE_ADDR and d_wdata==DONE_DATA.
  - mem_we stays 0 in ACC for that write, and d_ack is still given.
  - done is set on the ACC->ACK edge and stays 1 until reset.
  - Later accesses proceed normally.
- Simultaneous events: a new req arriving in ACC or ACK is only sampled in the next IDLE.
- Reset mid-operation: the FSM goes to IDLE, all acks=0, the in-flight request is dropped (memory is not written if rst=0 during ACC), done=0, last_grant=DATA.

Decomposition:
- Package rv_mem_pkg:
  - state enum (IDLE, ACC, ACK)
  - grant enum (GNT_IF, GNT_D)
  - default DONE_ADDR and DONE_DATA constants
- Sub-module rv_rr_arb2: two-input round-robin arbiter holding the last_grant register, with an update strobe asserted on the IDLE->ACC edge.

Test Plan:
- Fetch only: if_addr=0x8, mem word 2=0x00500093 -> if_ack high exactly 2 cycles after the req edge, if_rdata=0x00500093, mem_addr=2 during ACC.
- Data write then read: write 0x1234 to 0x40, then read 0x40 -> mem_we pulses once with mem_addr=0x10; read returns 0x1234; each d_ack is a single cycle.
- Tie, repeated: if_req and d_req both held high, each re-asserted after its ack -> grant order IF, D, IF, D; neither port gets two consecutive grants.
- Completion: d_we=1, d_addr=0xFFFF, d_wdata=0xDEAD -> d_ack given, mem_we stays 0, done=1 and stays 1 through subsequent fetches. A write of 0xDEAD to 0xFFFB does not set done.
- Wrap and misalign: read d_addr=0x1003 with LOGMEM_SIZE=10 -> mem_addr=0x000.
- Reset in ACC: rst=0 during a write's ACC -> no memory write, no ack, done=0, FSM in IDLE. After release, a tie is granted to fetch.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared types and default constants for the unified-memory arbiter.
//   state_e : arbiter FSM states (IDLE -> ACC -> ACK -> IDLE)
//   grant_e : which requester owns the current access
//   DEF_DONE_ADDR / DEF_DONE_DATA : default completion-write signature
package rv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACK  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  localparam logic [31:0] DEF_DONE_ADDR = 32'h0000_FFFF;
  localparam logic [31:0] DEF_DONE_DATA = 32'h0000_DEAD;

endpackage

// File: rtl/rv_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk      : clock
//   rst      : synchronous active-low reset (last grant returns to GNT_D)
//   req_if_i : fetch port request
//   req_d_i  : data port request
//   upd_i    : strobe; records gnt_o as the last grant
//   gnt_o    : combinational winner for the current requests
module rv_rr_arb2
  import rv_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_if_i,
  input  logic   req_d_i,
  input  logic   upd_i,
  output grant_e gnt_o
);

  grant_e last_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= GNT_D;
    end else if (upd_i) begin
      last_q <= gnt_o;
    end
  end

  // On a tie the port that was not served last wins.
  always_comb begin
    gnt_o = GNT_IF;
    if (req_if_i && req_d_i) begin
      gnt_o = (last_q == GNT_D) ? GNT_IF : GNT_D;
    end else if (req_d_i) begin
      gnt_o = GNT_D;
    end
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-port,
// synchronous-read memory, and traps the completion write.
//   clk, rst            : clock, synchronous active-low reset
//   if_req/if_addr      : fetch request and byte address
//   if_rdata/if_ack     : fetch data (valid with ack) and one-cycle ack
//   d_req/d_we/d_addr/d_wdata : data request, direction, address, write value
//   d_rdata/d_ack       : data read value (valid with ack) and one-cycle ack
//   mem_addr/mem_we/mem_wdata : word address, write enable, write data
//   mem_rdata           : memory read data, one cycle after the address
//   done                : sticky flag, set by the completion write
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int                 DPWIDTH     = 32,
  parameter int                 LOGMEM_SIZE = 10,
  parameter logic [DPWIDTH-1:0] DONE_ADDR   = DPWIDTH'(DEF_DONE_ADDR),
  parameter logic [DPWIDTH-1:0] DONE_DATA   = DPWIDTH'(DEF_DONE_DATA)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [DPWIDTH-1:0]     if_addr,
  output logic [DPWIDTH-1:0]     if_rdata,
  output logic                   if_ack,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [DPWIDTH-1:0]     d_addr,
  input  logic [DPWIDTH-1:0]     d_wdata,
  output logic [DPWIDTH-1:0]     d_rdata,
  output logic                   d_ack,
  output logic [LOGMEM_SIZE-1:0] mem_addr,
  output logic                   mem_we,
  output logic [DPWIDTH-1:0]     mem_wdata,
  input  logic [DPWIDTH-1:0]     mem_rdata,
  output logic                   done
);

  state_e                 state_q, state_d;
  grant_e                 gnt, gnt_q;
  logic                   we_q, hit_q, done_q;
  logic [LOGMEM_SIZE-1:0] addr_q;
  logic [DPWIDTH-1:0]     wdata_q;
  logic [DPWIDTH-1:0]     if_rdata_q, d_rdata_q;
  logic                   any_req, grant_upd;

  // Fetch addresses only use the word-index bits; the rest wrap away.
  logic unused_if_addr_bits;
  assign unused_if_addr_bits = ^{if_addr[DPWIDTH-1:LOGMEM_SIZE+2], if_addr[1:0]};

  assign any_req   = if_req | d_req;
  assign grant_upd = (state_q == IDLE) && any_req;
  assign done      = done_q;

  rv_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_if_i (if_req),
    .req_d_i  (d_req),
    .upd_i    (grant_upd),
    .gnt_o    (gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACC;
      ACC:     state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture on the IDLE->ACC edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q <= GNT_D;
      we_q  <= 1'b0;
      hit_q <= 1'b0;
    end else if (grant_upd) begin
      gnt_q <= gnt;
      if (gnt == GNT_D) begin
        we_q  <= d_we;
        hit_q <= d_we && (d_addr == DONE_ADDR) && (d_wdata == DONE_DATA);
      end else begin
        we_q  <= 1'b0;
        hit_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant_upd) begin
      if (gnt == GNT_D) begin
        addr_q  <= d_addr[LOGMEM_SIZE+1:2];
        wdata_q <= d_wdata;
      end else begin
        addr_q  <= if_addr[LOGMEM_SIZE+1:2];
        wdata_q <= '0;
      end
    end
  end

  // Completion flag and per-port held read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state_q == ACC && hit_q) done_q <= 1'b1;
      if (state_q == ACK) begin
        if (gnt_q == GNT_IF)  if_rdata_q <= mem_rdata;
        else if (!we_q)       d_rdata_q  <= mem_rdata;
      end
    end
  end

  // Outputs are qualified with rst so an access caught by reset neither
  // writes memory nor acknowledges in the reset cycle.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    if (rst) begin
      case (state_q)
        ACC: begin
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          mem_we    = we_q & ~hit_q;
        end
        ACK: begin
          if (gnt_q == GNT_IF) begin
            if_ack   = 1'b1;
            if_rdata = mem_rdata;
          end else begin
            d_ack = 1'b1;
            if (!we_q) d_rdata = mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
module tb_rv_mem_arbiter;

  localparam int DPW   = 32;
  localparam int LMS   = 10;
  localparam int DEPTH = 1 << LMS;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           if_req = 1'b0;
  logic [DPW-1:0] if_addr = '0;
  logic [DPW-1:0] if_rdata;
  logic           if_ack;
  logic           d_req = 1'b0;
  logic           d_we = 1'b0;
  logic [DPW-1:0] d_addr = '0;
  logic [DPW-1:0] d_wdata = '0;
  logic [DPW-1:0] d_rdata;
  logic           d_ack;
  logic [LMS-1:0] mem_addr;
  logic           mem_we;
  logic [DPW-1:0] mem_wdata;
  logic [DPW-1:0] mem_rdata;
  logic           done;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.DPWIDTH(DPW), .LOGMEM_SIZE(LMS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .done(done)
  );

  // Environment memory with a backdoor write port for preloading.
  logic [DPW-1:0] mem [DEPTH];
  logic           bd_we = 1'b0;
  logic [LMS-1:0] bd_addr = '0;
  logic [DPW-1:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we)       mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Reference state.
  logic [DPW-1:0] ref_mem [DEPTH];
  logic [DPW-1:0] ref_d_rdata  = '0;
  logic [DPW-1:0] ref_if_rdata = '0;

  int tests_run    = 0;
  int tests_failed = 0;
  int we_cnt       = 0;
  int gq[$];  // order of acks observed: 0 = fetch, 1 = data

  always @(negedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (if_ack) gq.push_back(0);
    if (d_ack)  gq.push_back(1);
  end

  function automatic int widx(input logic [DPW-1:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // One access on one port: returns the data seen with ack, the ack latency
  // in cycles after the sampling edge (-1 on timeout), the memory signals of
  // the cycle before ack, and the ack level one cycle after ack.
  task automatic access(input bit is_d, input bit we, input logic [DPW-1:0] addr,
                        input logic [DPW-1:0] wdata, output logic [DPW-1:0] rdata,
                        output int lat, output logic [LMS-1:0] acc_addr,
                        output logic acc_we, output logic [DPW-1:0] acc_wdata,
                        output logic ack_after);
    logic [LMS-1:0] pa;
    logic           pw;
    logic [DPW-1:0] pd;
    @(posedge clk); #1;
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1'b1; if_addr = addr; end
    @(posedge clk);
    lat = -1; rdata = '0; acc_addr = '0; acc_we = 1'b0; acc_wdata = '0;
    pa = '0; pw = 1'b0; pd = '0;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      @(negedge clk);
      if ((is_d && d_ack) || (!is_d && if_ack)) begin
        lat = k; rdata = is_d ? d_rdata : if_rdata;
        acc_addr = pa; acc_we = pw; acc_wdata = pd;
      end
      pa = mem_addr; pw = mem_we; pd = mem_wdata;
    end
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
    @(negedge clk);
    ack_after = is_d ? d_ack : if_ack;
  endtask

  // Repeating requester: asserts, holds until ack, drops for one idle cycle.
  task automatic requester(input bit is_d, input int n, output int tmo);
    bit got;
    tmo = 0;
    for (int i = 0; i < n; i++) begin
      if (is_d) d_req = 1'b1; else if_req = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 12 && !got; k++) begin
        @(negedge clk);
        got = is_d ? d_ack : if_ack;
      end
      if (is_d) d_req = 1'b0; else if_req = 1'b0;
      if (!got) tmo++;
      @(posedge clk); @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if (if_ack !== 1'b0)  begin tests_failed++; $display("FAIL reset_if_ack got %0b want 0", if_ack); end
    tests_run++; if (d_ack !== 1'b0)   begin tests_failed++; $display("FAIL reset_d_ack got %0b want 0", d_ack); end
    tests_run++; if (done !== 1'b0)    begin tests_failed++; $display("FAIL reset_done got %0b want 0", done); end
    tests_run++; if (mem_we !== 1'b0)  begin tests_failed++; $display("FAIL reset_mem_we got %0b want 0", mem_we); end
    tests_run++; if (mem_addr !== '0)  begin tests_failed++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
    tests_run++; if (if_rdata !== '0)  begin tests_failed++; $display("FAIL reset_if_rdata got %0h want 0", if_rdata); end
    tests_run++; if (d_rdata !== '0)   begin tests_failed++; $display("FAIL reset_d_rdata got %0h want 0", d_rdata); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_fetch();
    logic [DPW-1:0] rd, aw; logic [LMS-1:0] aa; logic awe, aft; int lat;
    access(1'b0, 1'b0, 32'h8, '0, rd, lat, aa, awe, aw, aft);
    tests_run++; if (lat !== 2)            begin tests_failed++; $display("FAIL fetch_latency got %0d want 2", lat); end
    tests_run++; if (rd !== 32'h00500093)  begin tests_failed++; $display("FAIL fetch_rdata got %h want 00500093", rd); end
    tests_run++; if (aa !== 10'd2)         begin tests_failed++; $display("FAIL fetch_mem_addr got %0h want 2", aa); end
    tests_run++; if (awe !== 1'b0)         begin tests_failed++; $display("FAIL fetch_mem_we got %0b want 0", awe); end
    tests_run++; if (aft !== 1'b0)         begin tests_failed++; $display("FAIL fetch_ack_width ack still %0b", aft); end
    tests_run++; if (if_rdata !== 32'h00500093) begin tests_failed++; $display("FAIL fetch_hold got %h want 00500093", if_rdata); end
    ref_if_rdata = 32'h00500093;
  endtask

  task automatic test_write_read();
    logic [DPW-1:0] rd, aw; logic [LMS-1:0] aa; logic awe, aft; int lat, w0;
    w0 = we_cnt;
    access(1'b1, 1'b1, 32'h40, 32'h1234, rd, lat, aa, awe, aw, aft);
    tests_run++; if (lat !== 2)       begin tests_failed++; $display("FAIL wr_latency got %0d want 2", lat); end
    tests_run++; if (aa !== 10'h10)   begin tests_failed++; $display("FAIL wr_mem_addr got %0h want 10", aa); end
    tests_run++; if (awe !== 1'b1)    begin tests_failed++; $display("FAIL wr_mem_we got %0b want 1", awe); end
    tests_run++; if (aw !== 32'h1234) begin tests_failed++; $display("FAIL wr_mem_wdata got %h want 1234", aw); end
    tests_run++; if (rd !== ref_d_rdata) begin tests_failed++; $display("FAIL wr_d_rdata_held got %h want %h", rd, ref_d_rdata); end
    tests_run++; if (aft !== 1'b0)    begin tests_failed++; $display("FAIL wr_ack_width ack still %0b", aft); end
    ref_mem[16] = 32'h1234;
    access(1'b1, 1'b0, 32'h40, '0, rd, lat, aa, awe, aw, aft);
    tests_run++; if (rd !== 32'h1234) begin tests_failed++; $display("FAIL rd_data got %h want 1234", rd); end
    tests_run++; if (awe !== 1'b0)    begin tests_failed++; $display("FAIL rd_mem_we got %0b want 0", awe); end
    tests_run++; if (aft !== 1'b0)    begin tests_failed++; $display("FAIL rd_ack_width ack still %0b", aft); end
    tests_run++; if (we_cnt - w0 !== 1) begin tests_failed++; $display("FAIL wr_we_pulses got %0d want 1", we_cnt - w0); end
    ref_d_rdata = 32'h1234;
  endtask

  task automatic test_wrap();
    logic [DPW-1:0] rd, aw; logic [LMS-1:0] aa; logic awe, aft; int lat;
    access(1'b1, 1'b0, 32'h1003, '0, rd, lat, aa, awe, aw, aft);
    tests_run++; if (aa !== 10'h000)   begin tests_failed++; $display("FAIL wrap_mem_addr got %0h want 0", aa); end
    tests_run++; if (rd !== ref_mem[0]) begin tests_failed++; $display("FAIL wrap_rdata got %h want %h", rd, ref_mem[0]); end
    ref_d_rdata = ref_mem[0];
  endtask

  task automatic test_random();
    logic [DPW-1:0] rd, aw, a, wd, exp; logic [LMS-1:0] aa; logic awe, aft; int lat, wi;
    bit is_d, we;
    for (int i = 0; i < 40; i++) begin
      is_d = 1'($urandom_range(0, 1));
      we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      a    = $urandom & 32'h0000_3FFF;
      wd   = $urandom;
      wi   = widx(a);
      access(is_d, we, a, wd, rd, lat, aa, awe, aw, aft);
      if (!is_d)   exp = ref_mem[wi];
      else if (we) exp = ref_d_rdata;
      else         exp = ref_mem[wi];
      tests_run++; if (lat !== 2)      begin tests_failed++; $display("FAIL rand%0d_latency got %0d want 2", i, lat); end
      tests_run++; if (aa !== LMS'(wi)) begin tests_failed++; $display("FAIL rand%0d_mem_addr got %0h want %0h", i, aa, wi); end
      tests_run++; if (awe !== we)     begin tests_failed++; $display("FAIL rand%0d_mem_we got %0b want %0b", i, awe, we); end
      tests_run++; if (rd !== exp)     begin tests_failed++; $display("FAIL rand%0d_rdata got %h want %h", i, rd, exp); end
      if (we) ref_mem[wi] = wd;
      else if (is_d) ref_d_rdata = exp;
      else ref_if_rdata = exp;
    end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rand_done got %0b want 0", done); end
  endtask

  task automatic test_done();
    logic [DPW-1:0] rd, aw; logic [LMS-1:0] aa; logic awe, aft; int lat;
    access(1'b1, 1'b1, 32'hFFFB, 32'hDEAD, rd, lat, aa, awe, aw, aft);
    tests_run++; if (awe !== 1'b1)  begin tests_failed++; $display("FAIL near_done_mem_we got %0b want 1", awe); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL near_done_flag got %0b want 0", done); end
    ref_mem[widx(32'hFFFB)] = 32'hDEAD;
    access(1'b1, 1'b1, 32'hFFFF, 32'hDEAD, rd, lat, aa, awe, aw, aft);
    tests_run++; if (lat !== 2)     begin tests_failed++; $display("FAIL done_ack_latency got %0d want 2", lat); end
    tests_run++; if (awe !== 1'b0)  begin tests_failed++; $display("FAIL done_mem_we got %0b want 0", awe); end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL done_flag got %0b want 1", done); end
    tests_run++; if (rd !== ref_d_rdata) begin tests_failed++; $display("FAIL done_d_rdata got %h want %h", rd, ref_d_rdata); end
    tests_run++; if (mem[1023] !== ref_mem[1023]) begin tests_failed++; $display("FAIL done_mem_untouched got %h want %h", mem[1023], ref_mem[1023]); end
    for (int i = 0; i < 2; i++) begin
      access(1'b0, 1'b0, 32'(4 * (i + 5)), '0, rd, lat, aa, awe, aw, aft);
      tests_run++; if (rd !== ref_mem[i + 5]) begin tests_failed++; $display("FAIL post_done_fetch%0d got %h want %h", i, rd, ref_mem[i + 5]); end
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL done_sticky%0d got %0b want 1", i, done); end
      ref_if_rdata = ref_mem[i + 5];
    end
  endtask

  task automatic test_reset_acc();
    int w0, q0, t0, t1;
    w0 = we_cnt;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;   // now in ACC
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL rstacc_mem_we got %0b want 0", mem_we); end
    d_req = 1'b0; d_we = 1'b0;
    q0 = gq.size();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (gq.size() !== q0)  begin tests_failed++; $display("FAIL rstacc_no_ack got %0d acks want 0", gq.size() - q0); end
    tests_run++; if (done !== 1'b0)     begin tests_failed++; $display("FAIL rstacc_done got %0b want 0", done); end
    tests_run++; if (we_cnt !== w0)     begin tests_failed++; $display("FAIL rstacc_we_pulses got %0d want 0", we_cnt - w0); end
    tests_run++; if (mem[32] !== ref_mem[32]) begin tests_failed++; $display("FAIL rstacc_mem got %h want %h", mem[32], ref_mem[32]); end
    tests_run++; if (d_rdata !== '0)    begin tests_failed++; $display("FAIL rstacc_d_rdata got %h want 0", d_rdata); end
    ref_d_rdata = '0; ref_if_rdata = '0;
    gq.delete();
    if_addr = 32'h0; d_addr = 32'h4;
    @(posedge clk); #1;
    fork
      requester(1'b0, 1, t0);
      requester(1'b1, 1, t1);
    join
    tests_run++; if (t0 + t1 !== 0) begin tests_failed++; $display("FAIL rstacc_tie_timeout got %0d timeouts want 0", t0 + t1); end
    tests_run++; if (gq.size() < 1 || gq[0] !== 0) begin tests_failed++; $display("FAIL rstacc_tie_first got %0d want 0 (fetch)", gq.size() > 0 ? gq[0] : -1); end
  endtask

  task automatic test_tie();
    logic [DPW-1:0] rd, aw; logic [LMS-1:0] aa; logic awe, aft; int lat, t0, t1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    gq.delete();
    d_we = 1'b0; if_addr = 32'h10; d_addr = 32'h20;
    fork
      requester(1'b0, 4, t0);
      requester(1'b1, 4, t1);
    join
    tests_run++; if (t0 + t1 !== 0) begin tests_failed++; $display("FAIL tie_timeout got %0d want 0", t0 + t1); end
    tests_run++; if (gq.size() !== 8) begin tests_failed++; $display("FAIL tie_count got %0d want 8", gq.size()); end
    for (int i = 0; i < 8 && i < gq.size(); i++) begin
      tests_run++; if (gq[i] !== i % 2) begin tests_failed++; $display("FAIL tie_order%0d got %0d want %0d", i, gq[i], i % 2); end
    end
    // After a lone fetch the next tie must go to data.
    access(1'b0, 1'b0, 32'h0, '0, rd, lat, aa, awe, aw, aft);
    gq.delete();
    @(posedge clk); #1;
    fork
      requester(1'b0, 1, t0);
      requester(1'b1, 1, t1);
    join
    tests_run++; if (gq.size() !== 2 || gq[0] !== 1 || gq[1] !== 0) begin tests_failed++; $display("FAIL tie_after_fetch got size %0d first %0d want 2 acks, data first", gq.size(), gq.size() > 0 ? gq[0] : -1); end
  endtask

  initial begin
    logic [DPW-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = (i == 2) ? 32'h00500093 : $urandom;
      ref_mem[i] = v;
      @(negedge clk);
      bd_we = 1'b1; bd_addr = LMS'(i); bd_data = v;
    end
    @(negedge clk); bd_we = 1'b0;
    test_reset();
    test_fetch();
    test_write_read();
    test_wrap();
    test_random();
    test_done();
    test_reset_acc();
    test_tie();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
